maxnet_vector_loader: RTL

Input-side front end for the 4-lane Maxnet competition datapath. It accepts IEEE-754 single-precision words one at a time over a valid/ready stream and assembles them into 4-word vectors. It buffers up to two complete vectors, presents one vector at a time on the `x1..x4` inputs of the Maxnet engine with a one-cycle `start` pulse, and releases the slot when the engine returns `done`. It is the producer end of the engine's `x1..x4` / start-done interface.

---
 rtl/maxnet_vector_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/maxnet_vector_loader.sv
// maxnet_vector_loader
//
// Front end for the 4-lane Maxnet competition engine. Single-precision words
// arrive one per handshake and are packed into 4-word vectors. Two vector
// slots act as a small ping-pong buffer. One vector at a time goes to the
// engine on x1..x4 with a single-cycle start pulse. The slot is freed when
// the engine answers with done.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   in_data   stream word; word0 -> x1 ... word3 -> x4
//   in_valid  in_data is valid
//   in_ready  loader can take a word (combinational from pending and rst)
//   x1..x4    registered vector presented to the engine
//   start     one-cycle pulse; x1..x4 valid and stable from this cycle on
//   nopos     presented vector has no strictly positive lane
//   done      engine finished the presented vector (single-cycle pulse)
//   pending   number of complete vectors held, 0..2
//
// WIDTH must be 32: the sign and exponent tests assume IEEE-754 single.

module maxnet_vector_loader #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] x4,
  output logic             start,
  output logic             nopos,
  input  logic             done,
  output logic [1:0]       pending
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Two slots of four lanes each.
  logic [1:0][3:0][WIDTH-1:0] slot_q;

  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic [1:0] lc_q, lc_d;
  logic [1:0] pending_q, pending_d;

  logic [3:0][WIDTH-1:0] x_q;
  logic                  start_q;
  logic                  nopos_q, nopos_d;

  logic accept;
  logic push;
  logic pop;
  logic load;

  // A lane is non-positive if its sign is set or its exponent is zero.
  // The zero-exponent case covers +0 and positive denormals. A NaN with
  // sign 0 has a non-zero exponent, so it counts as positive.
  function automatic logic lane_nonpos(input logic sgn, input logic [7:0] expo);
    return sgn | (expo == 8'd0);
  endfunction

  // The partially filled slot is always slot[wp]. That slot is free
  // whenever fewer than two complete vectors are held.
  assign in_ready = rst & (pending_q < 2'd2);
  assign accept   = in_valid & in_ready;
  assign push     = accept & (lc_q == 2'd3);

  // Write side: lane pointer, slot pointer.
  always_comb begin
    lc_d = lc_q;
    wp_d = wp_q;
    if (accept) begin
      lc_d = lc_q + 2'd1;
    end
    if (push) begin
      wp_d = ~wp_q;
    end
  end

  // Read-side FSM and output load.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pending_q != 2'd0) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rp_d = rp_q ^ pop;

  // A push and a pop on the same edge cancel out.
  always_comb begin
    pending_d = pending_q;
    unique case ({push, pop})
      2'b10:   pending_d = pending_q + 2'd1;
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase
  end

  always_comb begin
    nopos_d = lane_nonpos(slot_q[rp_q][0][WIDTH-1], slot_q[rp_q][0][30:23])
            & lane_nonpos(slot_q[rp_q][1][WIDTH-1], slot_q[rp_q][1][30:23])
            & lane_nonpos(slot_q[rp_q][2][WIDTH-1], slot_q[rp_q][2][30:23])
            & lane_nonpos(slot_q[rp_q][3][WIDTH-1], slot_q[rp_q][3][30:23]);
  end

  // Slot contents need no reset. Reset only clears the pointers and count,
  // and those decide which data is ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_q[wp_q][lc_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      lc_q      <= 2'd0;
      pending_q <= 2'd0;
      x_q       <= '0;
      start_q   <= 1'b0;
      nopos_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      lc_q      <= lc_d;
      pending_q <= pending_d;
      // start is high exactly during the ISSUE cycle.
      start_q   <= load;
      if (load) begin
        x_q     <= slot_q[rp_q];
        nopos_q <= nopos_d;
      end
    end
  end

  assign x1      = x_q[0];
  assign x2      = x_q[1];
  assign x3      = x_q[2];
  assign x4      = x_q[3];
  assign start   = start_q;
  assign nopos   = nopos_q;
  assign pending = pending_q;

endmodule
